uart_tx_feeder: RTL and testbench

//  Byte-queue front end for the UART transmitter, in the tx_clk domain. Buffers

---
 rtl/uart_tx_feeder.sv | 145 ++++++++++++++
 tb/tb_uart_tx_feeder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_feeder
// Description : Byte FIFO with per-byte parity settings that feeds a UART
//               transmitter one frame at a time, handshaking on its busy.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          tx_clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_parity_en,
  input  logic                          wr_parity_odd,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  input  logic                          busy,
  output logic                          tx_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          parity_en,
  output logic                          odd_r_even_parity,
  output logic                          sent,
  output logic                          timeout
);

  localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_ADDR_W + 1;
  localparam int c_TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_ENT_W  = DATA_WIDTH + 2;
  localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_IDLE = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_ENT_W-1:0]    r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0]   r_wr_ptr;
  logic [c_ADDR_W-1:0]   r_rd_ptr;
  logic [c_TMR_W-1:0]    r_timer;

  logic                  w_wr_accept;
  logic                  w_pop;
  logic [c_ENT_W-1:0]    w_head;
  logic [c_CNT_W-1:0]    w_count_nxt;

  // full is taken from the registered count, so a same-cycle pop never frees a slot
  assign w_wr_accept = wr_en && !full;
  assign w_pop       = (r_state == S_IDLE) && !empty && !busy;
  assign w_head      = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = count;
    case ({w_wr_accept, w_pop})
      2'b10:   w_count_nxt = count + c_CNT_W'(1);
      2'b01:   w_count_nxt = count - c_CNT_W'(1);
      default: w_count_nxt = count;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= {wr_parity_en, wr_parity_odd, wr_data};
    end
  end

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_wr_ptr          <= '0;
      r_rd_ptr          <= '0;
      r_timer           <= '0;
      count             <= '0;
      full              <= 1'b0;
      empty             <= 1'b1;
      overflow          <= 1'b0;
      tx_en             <= 1'b0;
      data_in           <= '0;
      parity_en         <= 1'b0;
      odd_r_even_parity <= 1'b0;
      sent              <= 1'b0;
      timeout           <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      sent     <= 1'b0;
      timeout  <= 1'b0;
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
      end
      count <= w_count_nxt;
      full  <= (w_count_nxt == c_FULL);
      empty <= (w_count_nxt == '0);

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            data_in           <= w_head[DATA_WIDTH-1:0];
            odd_r_even_parity <= w_head[DATA_WIDTH];
            parity_en         <= w_head[DATA_WIDTH+1];
            tx_en             <= 1'b1;
            r_timer           <= '0;
            r_state           <= S_REQ;
          end
        end
        S_REQ: begin
          if (busy) begin
            tx_en   <= 1'b0;
            r_state <= S_WAIT_IDLE;
          end else if (r_timer == c_TMR_MAX) begin
            // transmitter never answered; the popped entry is dropped
            tx_en   <= 1'b0;
            timeout <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + c_TMR_W'(1);
          end
        end
        S_WAIT_IDLE: begin
          if (!busy) begin
            sent    <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          tx_en   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_feeder
// Description : Directed self-checking bench; the bench plays the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

  logic       tx_clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_parity_en = 1'b0;
  logic       wr_parity_odd = 1'b0;
  logic       full, empty, overflow;
  logic [4:0] count;
  logic       busy = 1'b0;
  logic       tx_en;
  logic [7:0] data_in;
  logic       parity_en, odd_r_even_parity, sent, timeout;

  int total = 0;
  int bad   = 0;

  uart_tx_feeder #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(16),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .tx_clk            (tx_clk),
    .rst               (rst),
    .wr_en             (wr_en),
    .wr_data           (wr_data),
    .wr_parity_en      (wr_parity_en),
    .wr_parity_odd     (wr_parity_odd),
    .full              (full),
    .empty             (empty),
    .count             (count),
    .overflow          (overflow),
    .busy              (busy),
    .tx_en             (tx_en),
    .data_in           (data_in),
    .parity_en         (parity_en),
    .odd_r_even_parity (odd_r_even_parity),
    .sent              (sent),
    .timeout           (timeout)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic tick;
    @(posedge tx_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d, input logic pe, input logic po);
    wr_en         = 1'b1;
    wr_data       = d;
    wr_parity_en  = pe;
    wr_parity_odd = po;
    tick();
    wr_en = 1'b0;
  endtask

  // Acts as the transmitter for one frame: wait for the request, check the
  // presented byte/parity, run busy for a few cycles, then expect sent.
  task automatic xmit(input logic [7:0] d, input logic pe, input logic po);
    int n;
    n = 0;
    while (tx_en !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("req_seen", {31'd0, tx_en}, 32'd1);
    chk("data_in", {24'd0, data_in}, {24'd0, d});
    chk("parity", {30'd0, parity_en, odd_r_even_parity}, {30'd0, pe, po});
    busy = 1'b1;
    tick();
    chk("req_drop", {31'd0, tx_en}, 32'd0);
    tick();
    tick();
    busy = 1'b0;
    tick();
    chk("sent", {31'd0, sent}, 32'd1);
  endtask

  initial begin
    int k;
    int ovf;

    // reset state
    tick();
    tick();
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_outs", {19'd0, tx_en, data_in, parity_en, odd_r_even_parity, overflow, sent, timeout},
        32'd0);
    rst = 1'b0;
    tick();

    // first-write latency into an idle, empty queue
    wr_en = 1'b1; wr_data = 8'h11; wr_parity_en = 1'b0; wr_parity_odd = 1'b0;
    tick();
    wr_en = 1'b0;
    chk("lat_empty", {31'd0, empty}, 32'd0);
    chk("lat_txen0", {31'd0, tx_en}, 32'd0);
    tick();
    chk("lat_txen1", {31'd0, tx_en}, 32'd1);
    chk("lat_count", {27'd0, count}, 32'd0);
    xmit(8'h11, 1'b0, 1'b0);

    // three frames in order
    busy = 1'b1;
    wr(8'hFA, 1'b0, 1'b0);
    wr(8'hFB, 1'b0, 1'b0);
    wr(8'hFC, 1'b1, 1'b1);
    tick();
    chk("three_count", {27'd0, count}, 32'd3);
    chk("no_pop_busy", {31'd0, tx_en}, 32'd0);
    busy = 1'b0;
    xmit(8'hFA, 1'b0, 1'b0);
    xmit(8'hFB, 1'b0, 1'b0);
    xmit(8'hFC, 1'b1, 1'b1);
    tick();
    chk("three_drained", {26'd0, empty, count}, {26'd0, 1'b1, 5'd0});

    // overflow: 18 writes while the transmitter stays busy
    busy = 1'b1;
    ovf = 0;
    for (int i = 0; i < 18; i++) begin
      wr(8'h40 + 8'(i), 1'b0, 1'b0);
      if (overflow === 1'b1) ovf++;
      if (i == 14) chk("full_at_15", {31'd0, full}, 32'd0);
      if (i == 15) chk("full_at_16", {31'd0, full}, 32'd1);
    end
    tick();
    if (overflow === 1'b1) ovf++;
    chk("ovf_pulses", ovf, 32'd2);
    chk("full_count", {27'd0, count}, 32'd16);
    busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      xmit(8'h40 + 8'(i), 1'b0, 1'b0);
    end

    // timeout: request never answered
    busy = 1'b1;
    wr(8'hA5, 1'b1, 1'b0);
    wr(8'h5A, 1'b0, 1'b1);
    busy = 1'b0;
    tick();
    chk("to_req", {31'd0, tx_en}, 32'd1);
    k = 0;
    while (timeout !== 1'b1 && k < 2000) begin
      tick();
      k++;
    end
    chk("to_cycles", k, 32'd1024);
    chk("to_txen", {31'd0, tx_en}, 32'd0);
    chk("to_count", {27'd0, count}, 32'd1);
    tick();
    chk("to_pulse_end", {31'd0, timeout}, 32'd0);
    xmit(8'h5A, 1'b0, 1'b1);

    // simultaneous write+pop at count=5, then 20 entries through the wrap
    busy = 1'b1;
    for (int i = 0; i < 5; i++) wr(8'(i), 1'b0, 1'b0);
    chk("five_count", {27'd0, count}, 32'd5);
    busy = 1'b0;
    wr(8'd5, 1'b0, 1'b0);
    chk("wp_count", {27'd0, count}, 32'd5);
    chk("wp_pop", {23'd0, tx_en, data_in}, {23'd0, 1'b1, 8'd0});
    xmit(8'd0, 1'b0, 1'b0);
    busy = 1'b1;
    for (int i = 6; i < 16; i++) wr(8'(i), 1'b0, 1'b0);
    busy = 1'b0;
    for (int i = 1; i < 16; i++) xmit(8'(i), 1'b0, 1'b0);
    for (int i = 16; i < 20; i++) wr(8'(i), 1'b0, 1'b0);
    for (int i = 16; i < 20; i++) xmit(8'(i), 1'b0, 1'b0);

    // reset while a frame is in flight with 4 entries queued
    for (int i = 0; i < 5; i++) wr(8'h30 + 8'(i), 1'b0, 1'b0);
    busy = 1'b1;
    tick();
    chk("mid_count", {27'd0, count}, 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst", {25'd0, empty, tx_en, count}, {25'd0, 1'b1, 1'b0, 5'd0});
    wr(8'h77, 1'b1, 1'b1);
    tick();
    tick();
    chk("mid_hold", {26'd0, tx_en, count}, {26'd0, 1'b0, 5'd1});
    busy = 1'b0;
    xmit(8'h77, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
